// File: rtl/ahb_burst_tracker_if.sv
// AHB-Lite read-burst tracker bus bundle.
// The master modport drives the AHB address/data-phase signals and observes
// the delivered read beats; the slave modport is the tracker's view.
interface ahb_burst_tracker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hburst;
    logic [2:0]        hsize;
    logic              hready;
    logic [DATA_W-1:0] hrdata;

    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [3:0]        rd_beat;
    logic              rd_last;
    logic              burst_err;

    modport master (
        output haddr, htrans, hwrite, hburst, hsize, hready, hrdata,
        input  rd_valid, rd_addr, rd_data, rd_beat, rd_last, burst_err
    );

    modport slave (
        input  haddr, htrans, hwrite, hburst, hsize, hready, hrdata,
        output rd_valid, rd_addr, rd_data, rd_beat, rd_last, burst_err
    );
endinterface

// File: rtl/ahb_burst_tracker.sv
// AHB-Lite read-burst tracker for the I-cache refill path.
// Follows the address/data pipeline, numbers the beats of every burst type
// and delivers one registered read beat per completed data phase.
// Optional macro AHB_TRK_CHECK_EN builds the SEQ-address / HSIZE / 1 KB
// checker that drives burst_err; without it burst_err is tied low.
// ADDR_W/DATA_W must match the parameters of the connected interface.
module ahb_burst_tracker #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rstn,
    ahb_burst_tracker_if.slave bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIXED = 2'd1,
        ST_UNDEF = 2'd2
    } state_t;

    // Index of the final beat of a fixed-length burst.
    function automatic logic [3:0] final_beat(input logic [2:0] burst);
        logic [3:0] idx;
        case (burst)
            HBURST_WRAP4, HBURST_INCR4:   idx = 4'd3;
            HBURST_WRAP8, HBURST_INCR8:   idx = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: idx = 4'd15;
            default:                      idx = 4'd0;
        endcase
        return idx;
    endfunction

`ifdef AHB_TRK_CHECK_EN
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONES = {ADDR_W{1'b1}};
    localparam logic [2:0]        MAX_HSIZE = 3'($clog2(DATA_W / 8));

    // Address of the beat after addr; wrapping bursts keep the bits above
    // the wrap boundary and roll the offset below it.
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [2:0]        size,
        input logic [2:0]        burst
    );
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        step = ADDR_ONE << size;
        case (burst)
            HBURST_WRAP4:  mask = (step << 2'd2) - ADDR_ONE;
            HBURST_WRAP8:  mask = (step << 2'd3) - ADDR_ONE;
            HBURST_WRAP16: mask = (step << 3'd4) - ADDR_ONE;
            default:       mask = ADDR_ONES;
        endcase
        return (addr & ~mask) | ((addr + step) & mask);
    endfunction

    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic [2:0]        size_q, size_d;
    logic              size_err_s;
    logic              kb_cross_s;
`else
    // hsize only feeds the checker, which this build leaves out.
    logic unused_hsize_s;
    assign unused_hsize_s = ^bus.hsize;
`endif

    state_t            state_q, state_d;
    logic [2:0]        burst_q, burst_d;
    logic [3:0]        beat_q, beat_d;

    logic              dp_valid_q, dp_valid_d;
    logic              dp_write_q, dp_write_d;
    logic [ADDR_W-1:0] dp_addr_q, dp_addr_d;
    logic [3:0]        dp_beat_q, dp_beat_d;
    logic              dp_last_q, dp_last_d;

    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [3:0]        rd_beat_q, rd_beat_d;
    logic              rd_last_q, rd_last_d;
    logic              burst_err_q, burst_err_d;

    logic              is_nonseq_s;
    logic              is_seq_s;
    logic              seq_last_s;

    // Next-state: burst FSM, beat numbering, data-phase latch and beat delivery.
    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        dp_valid_d  = dp_valid_q;
        dp_write_d  = dp_write_q;
        dp_addr_d   = dp_addr_q;
        dp_beat_d   = dp_beat_q;
        dp_last_d   = dp_last_q;
        rd_valid_d  = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        rd_beat_d   = rd_beat_q;
        rd_last_d   = rd_last_q;
        burst_err_d = 1'b0;
`ifdef AHB_TRK_CHECK_EN
        exp_addr_d  = exp_addr_q;
        size_d      = size_q;
        size_err_s  = (bus.hsize > MAX_HSIZE);
        kb_cross_s  = (state_q == ST_UNDEF) &&
                      (bus.haddr[ADDR_W-1:10] != dp_addr_q[ADDR_W-1:10]);
`endif

        // SEQ outside a burst has nothing to continue and is not tracked.
        is_nonseq_s = (bus.htrans == HTRANS_NONSEQ);
        is_seq_s    = (bus.htrans == HTRANS_SEQ) && (state_q != ST_IDLE);
        seq_last_s  = (state_q == ST_FIXED) && (beat_q == final_beat(burst_q));

        if (bus.hready) begin
            // The pending data phase completes on this edge.
            if (dp_valid_q && !dp_write_q) begin
                rd_valid_d = 1'b1;
                rd_addr_d  = dp_addr_q;
                rd_data_d  = bus.hrdata;
                rd_beat_d  = dp_beat_q;
                rd_last_d  = dp_last_q;
            end else begin
                rd_valid_d = 1'b0;
            end

            dp_valid_d = is_nonseq_s || is_seq_s;

            if (is_nonseq_s) begin
                // New burst (or early termination of the current one).
                dp_addr_d  = bus.haddr;
                dp_write_d = bus.hwrite;
                dp_beat_d  = 4'd0;
                dp_last_d  = (bus.hburst == HBURST_SINGLE);
                burst_d    = bus.hburst;
                beat_d     = 4'd1;
                case (bus.hburst)
                    HBURST_SINGLE: state_d = ST_IDLE;
                    HBURST_INCR:   state_d = ST_UNDEF;
                    default:       state_d = ST_FIXED;
                endcase
`ifdef AHB_TRK_CHECK_EN
                size_d      = bus.hsize;
                exp_addr_d  = next_addr(bus.haddr, bus.hsize, bus.hburst);
                burst_err_d = size_err_s;
`endif
            end else if (is_seq_s) begin
                // Continuation beat; tracking follows the presented address,
                // which also resyncs after a checker error.
                dp_addr_d  = bus.haddr;
                dp_write_d = bus.hwrite;
                dp_beat_d  = beat_q;
                dp_last_d  = seq_last_s;
                beat_d     = (beat_q == 4'd15) ? 4'd15 : beat_q + 4'd1;
                if (seq_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
`ifdef AHB_TRK_CHECK_EN
                exp_addr_d  = next_addr(bus.haddr, size_q, burst_q);
                burst_err_d = (bus.haddr != exp_addr_q) || size_err_s || kb_cross_s;
`endif
            end else if (bus.htrans == HTRANS_IDLE) begin
                state_d = ST_IDLE;
            end else begin
                // BUSY, or SEQ with no burst open: tracking holds.
                state_d = state_q;
            end
        end else begin
            // Wait state: everything holds.
            rd_valid_d = 1'b0;
        end
    end

    // State, tracking, data-phase and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            burst_q     <= 3'd0;
            beat_q      <= 4'd0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_addr_q   <= {ADDR_W{1'b0}};
            dp_beat_q   <= 4'd0;
            dp_last_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= {ADDR_W{1'b0}};
            rd_data_q   <= {DATA_W{1'b0}};
            rd_beat_q   <= 4'd0;
            rd_last_q   <= 1'b0;
            burst_err_q <= 1'b0;
`ifdef AHB_TRK_CHECK_EN
            exp_addr_q  <= {ADDR_W{1'b0}};
            size_q      <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            dp_addr_q   <= dp_addr_d;
            dp_beat_q   <= dp_beat_d;
            dp_last_q   <= dp_last_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            rd_beat_q   <= rd_beat_d;
            rd_last_q   <= rd_last_d;
            burst_err_q <= burst_err_d;
`ifdef AHB_TRK_CHECK_EN
            exp_addr_q  <= exp_addr_d;
            size_q      <= size_d;
`endif
        end
    end

    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_beat   = rd_beat_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.burst_err = burst_err_q;
endmodule

// File: tb/tb_ahb_burst_tracker.sv
// Directed bench for ahb_burst_tracker: drives AHB address/data phases cycle
// by cycle and compares each delivered beat with hand-computed values.
// Read data is DA7A_0000 ^ beat address so data alignment is checked too.
module tb_ahb_burst_tracker;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_WRAP4 = 3'd2, B_INCR4 = 3'd3,
                           B_WRAP8 = 3'd4, B_INCR8 = 3'd5, B_INCR16 = 3'd7;
`ifdef AHB_TRK_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ahb_burst_tracker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    ahb_burst_tracker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] dp_addr_tb = 32'h0;
    logic        wr_tb = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus cycle; outputs are sampled 1 ns after the clock edge.
    task automatic bus_cycle(input logic [1:0] trans, input logic [31:0] addr,
                             input logic [2:0] burst, input logic [2:0] size, input logic ready);
        bus_if.htrans = trans;
        bus_if.haddr  = addr;
        bus_if.hburst = burst;
        bus_if.hsize  = size;
        bus_if.hready = ready;
        bus_if.hwrite = wr_tb;
        bus_if.hrdata = 32'hDA7A_0000 ^ dp_addr_tb;
        @(posedge clk);
        #1;
        if (ready && trans[1]) dp_addr_tb = addr;
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] addr, input logic [3:0] beat,
                               input logic last, input logic err);
        check_eq({tag, ".valid"}, 64'(bus_if.rd_valid), 64'd1);
        check_eq({tag, ".addr"},  64'(bus_if.rd_addr),  64'(addr));
        check_eq({tag, ".data"},  64'(bus_if.rd_data),  64'(32'hDA7A_0000 ^ addr));
        check_eq({tag, ".beat"},  64'(bus_if.rd_beat),  64'(beat));
        check_eq({tag, ".last"},  64'(bus_if.rd_last),  64'(last));
        check_eq({tag, ".err"},   64'(bus_if.burst_err), 64'(err));
    endtask

    task automatic expect_none(input string tag, input logic err);
        check_eq({tag, ".valid"}, 64'(bus_if.rd_valid), 64'd0);
        check_eq({tag, ".err"},   64'(bus_if.burst_err), 64'(err));
    endtask

    task automatic expect_all_zero(input string tag);
        check_eq({tag, ".valid"}, 64'(bus_if.rd_valid), 64'd0);
        check_eq({tag, ".addr"},  64'(bus_if.rd_addr),  64'd0);
        check_eq({tag, ".data"},  64'(bus_if.rd_data),  64'd0);
        check_eq({tag, ".beat"},  64'(bus_if.rd_beat),  64'd0);
        check_eq({tag, ".last"},  64'(bus_if.rd_last),  64'd0);
        check_eq({tag, ".err"},   64'(bus_if.burst_err), 64'd0);
    endtask

    initial begin
        logic [31:0] w4 [4];
        logic [31:0] w8 [6];
        w4 = '{32'h38, 32'h3C, 32'h30, 32'h34};
        w8 = '{32'h98, 32'h9C, 32'h80, 32'h84, 32'h88, 32'h8C};

        bus_if.htrans = T_IDLE; bus_if.haddr = 32'h0; bus_if.hburst = B_SINGLE;
        bus_if.hsize = 3'd2; bus_if.hready = 1'b1; bus_if.hwrite = 1'b0; bus_if.hrdata = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        expect_all_zero("reset");
        rstn = 1'b1;
        bus_cycle(T_IDLE, 32'h0, B_SINGLE, 3'd2, 1'b1);
        expect_none("idle", 1'b0);

        // SINGLE read at 0x100
        bus_cycle(T_NSEQ, 32'h100, B_SINGLE, 3'd2, 1'b1); expect_none("single.a", 1'b0);
        bus_cycle(T_IDLE, 32'h0, B_SINGLE, 3'd2, 1'b1);   expect_beat("single", 32'h100, 4'd0, 1'b1, 1'b0);
        bus_cycle(T_IDLE, 32'h0, B_SINGLE, 3'd2, 1'b1);   expect_none("single.z", 1'b0);

        // Write SINGLE completes silently
        wr_tb = 1'b1;
        bus_cycle(T_NSEQ, 32'h140, B_SINGLE, 3'd2, 1'b1); expect_none("write.a", 1'b0);
        wr_tb = 1'b0;
        bus_cycle(T_IDLE, 32'h0, B_SINGLE, 3'd2, 1'b1);   expect_none("write.d", 1'b0);

        // WRAP4 word from 0x38
        bus_cycle(T_NSEQ, w4[0], B_WRAP4, 3'd2, 1'b1); expect_none("wrap4.a", 1'b0);
        for (int i = 1; i < 4; i++) begin
            bus_cycle(T_SEQ, w4[i], B_WRAP4, 3'd2, 1'b1);
            expect_beat($sformatf("wrap4.b%0d", i - 1), w4[i-1], 4'(i - 1), 1'b0, 1'b0);
        end
        bus_cycle(T_IDLE, 32'h0, B_WRAP4, 3'd2, 1'b1); expect_beat("wrap4.b3", w4[3], 4'd3, 1'b1, 1'b0);
        bus_cycle(T_IDLE, 32'h0, B_WRAP4, 3'd2, 1'b1); expect_none("wrap4.z", 1'b0);

        // INCR8 halfword from 0x200, two wait states in the data phase of beat 3
        bus_cycle(T_NSEQ, 32'h200, B_INCR8, 3'd1, 1'b1); expect_none("incr8.a", 1'b0);
        for (int i = 1; i < 8; i++) begin
            if (i == 4) begin
                bus_cycle(T_SEQ, 32'h208, B_INCR8, 3'd1, 1'b0); expect_none("incr8.w0", 1'b0);
                bus_cycle(T_SEQ, 32'h208, B_INCR8, 3'd1, 1'b0); expect_none("incr8.w1", 1'b0);
            end
            bus_cycle(T_SEQ, 32'h200 + 32'(2 * i), B_INCR8, 3'd1, 1'b1);
            expect_beat($sformatf("incr8.b%0d", i - 1), 32'h200 + 32'(2 * (i - 1)), 4'(i - 1), 1'b0, 1'b0);
        end
        bus_cycle(T_IDLE, 32'h0, B_INCR8, 3'd1, 1'b1); expect_beat("incr8.b7", 32'h20E, 4'd7, 1'b1, 1'b0);
        bus_cycle(T_IDLE, 32'h0, B_INCR8, 3'd1, 1'b1); expect_none("incr8.z", 1'b0);

        // WRAP8 word from 0x98, BUSY after beat 2, NONSEQ INCR 0x400 after beat 5
        bus_cycle(T_NSEQ, w8[0], B_WRAP8, 3'd2, 1'b1); expect_none("wrap8.a", 1'b0);
        bus_cycle(T_SEQ,  w8[1], B_WRAP8, 3'd2, 1'b1); expect_beat("wrap8.b0", w8[0], 4'd0, 1'b0, 1'b0);
        bus_cycle(T_SEQ,  w8[2], B_WRAP8, 3'd2, 1'b1); expect_beat("wrap8.b1", w8[1], 4'd1, 1'b0, 1'b0);
        bus_cycle(T_BUSY, w8[3], B_WRAP8, 3'd2, 1'b1); expect_beat("wrap8.b2", w8[2], 4'd2, 1'b0, 1'b0);
        bus_cycle(T_SEQ,  w8[3], B_WRAP8, 3'd2, 1'b1); expect_none("wrap8.busy", 1'b0);
        bus_cycle(T_SEQ,  w8[4], B_WRAP8, 3'd2, 1'b1); expect_beat("wrap8.b3", w8[3], 4'd3, 1'b0, 1'b0);
        bus_cycle(T_SEQ,  w8[5], B_WRAP8, 3'd2, 1'b1); expect_beat("wrap8.b4", w8[4], 4'd4, 1'b0, 1'b0);
        bus_cycle(T_NSEQ, 32'h400, B_INCR, 3'd2, 1'b1); expect_beat("wrap8.b5", w8[5], 4'd5, 1'b0, 1'b0);
        bus_cycle(T_SEQ,  32'h404, B_INCR, 3'd2, 1'b1); expect_beat("new.b0", 32'h400, 4'd0, 1'b0, 1'b0);
        bus_cycle(T_IDLE, 32'h0, B_INCR, 3'd2, 1'b1);   expect_beat("new.b1", 32'h404, 4'd1, 1'b0, 1'b0);
        bus_cycle(T_IDLE, 32'h0, B_INCR, 3'd2, 1'b1);   expect_none("new.z", 1'b0);

        // INCR4 from 0x10 with beat 2 presented at 0x20
        bus_cycle(T_NSEQ, 32'h10, B_INCR4, 3'd2, 1'b1); expect_none("bad.a", 1'b0);
        bus_cycle(T_SEQ,  32'h14, B_INCR4, 3'd2, 1'b1); expect_beat("bad.b0", 32'h10, 4'd0, 1'b0, 1'b0);
        bus_cycle(T_SEQ,  32'h20, B_INCR4, 3'd2, 1'b1); expect_beat("bad.b1", 32'h14, 4'd1, 1'b0, CHK);
        bus_cycle(T_SEQ,  32'h24, B_INCR4, 3'd2, 1'b1); expect_beat("bad.b2", 32'h20, 4'd2, 1'b0, 1'b0);
        bus_cycle(T_IDLE, 32'h0, B_INCR4, 3'd2, 1'b1);  expect_beat("bad.b3", 32'h24, 4'd3, 1'b1, 1'b0);
        bus_cycle(T_IDLE, 32'h0, B_INCR4, 3'd2, 1'b1);  expect_none("bad.z", 1'b0);

        // Oversized hsize on a 32-bit bus
        bus_cycle(T_NSEQ, 32'h300, B_SINGLE, 3'd3, 1'b1); expect_none("hsize.a", CHK);
        bus_cycle(T_IDLE, 32'h0, B_SINGLE, 3'd2, 1'b1);   expect_beat("hsize", 32'h300, 4'd0, 1'b1, 1'b0);

        // Undefined-length INCR crossing 0x400
        bus_cycle(T_NSEQ, 32'h3F8, B_INCR, 3'd2, 1'b1); expect_none("kb.a", 1'b0);
        bus_cycle(T_SEQ,  32'h3FC, B_INCR, 3'd2, 1'b1); expect_beat("kb.b0", 32'h3F8, 4'd0, 1'b0, 1'b0);
        bus_cycle(T_SEQ,  32'h400, B_INCR, 3'd2, 1'b1); expect_beat("kb.b1", 32'h3FC, 4'd1, 1'b0, CHK);
        bus_cycle(T_IDLE, 32'h0, B_INCR, 3'd2, 1'b1);   expect_beat("kb.b2", 32'h400, 4'd2, 1'b0, 1'b0);

        // INCR4 wrapping through address 0, final beat overlapping a new NONSEQ
        bus_cycle(T_NSEQ, 32'hFFFF_FFF8, B_INCR4, 3'd2, 1'b1); expect_none("ovf.a", 1'b0);
        bus_cycle(T_SEQ,  32'hFFFF_FFFC, B_INCR4, 3'd2, 1'b1); expect_beat("ovf.b0", 32'hFFFF_FFF8, 4'd0, 1'b0, 1'b0);
        bus_cycle(T_SEQ,  32'h0, B_INCR4, 3'd2, 1'b1);         expect_beat("ovf.b1", 32'hFFFF_FFFC, 4'd1, 1'b0, 1'b0);
        bus_cycle(T_SEQ,  32'h4, B_INCR4, 3'd2, 1'b1);         expect_beat("ovf.b2", 32'h0, 4'd2, 1'b0, 1'b0);
        bus_cycle(T_NSEQ, 32'h100, B_SINGLE, 3'd2, 1'b1);      expect_beat("ovf.b3", 32'h4, 4'd3, 1'b1, 1'b0);
        bus_cycle(T_IDLE, 32'h0, B_SINGLE, 3'd2, 1'b1);        expect_beat("ovf.next", 32'h100, 4'd0, 1'b1, 1'b0);

        // Undefined-length INCR of 18 beats: index saturates at 15
        bus_cycle(T_NSEQ, 32'h700, B_INCR, 3'd2, 1'b1); expect_none("sat.a", 1'b0);
        for (int i = 1; i < 18; i++) begin
            bus_cycle(T_SEQ, 32'h700 + 32'(4 * i), B_INCR, 3'd2, 1'b1);
            expect_beat($sformatf("sat.b%0d", i - 1), 32'h700 + 32'(4 * (i - 1)),
                        (i - 1 > 15) ? 4'd15 : 4'(i - 1), 1'b0, 1'b0);
        end
        bus_cycle(T_IDLE, 32'h0, B_INCR, 3'd2, 1'b1); expect_beat("sat.b17", 32'h744, 4'd15, 1'b0, 1'b0);

        // Reset during beat 2 of INCR16
        bus_cycle(T_NSEQ, 32'h500, B_INCR16, 3'd2, 1'b1); expect_none("rst.a", 1'b0);
        bus_cycle(T_SEQ,  32'h504, B_INCR16, 3'd2, 1'b1); expect_beat("rst.b0", 32'h500, 4'd0, 1'b0, 1'b0);
        bus_cycle(T_SEQ,  32'h508, B_INCR16, 3'd2, 1'b1); expect_beat("rst.b1", 32'h504, 4'd1, 1'b0, 1'b0);
        bus_if.htrans = T_SEQ; bus_if.haddr = 32'h50C;
        #2 rstn = 1'b0;
        #1 expect_all_zero("rst.async");
        @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_cycle(T_SEQ, 32'h510 + 32'(4 * i), B_INCR16, 3'd2, 1'b1);
            expect_none($sformatf("rst.quiet%0d", i), 1'b0);
        end
        bus_cycle(T_NSEQ, 32'h600, B_SINGLE, 3'd2, 1'b1); expect_none("rst.nseq", 1'b0);
        bus_cycle(T_IDLE, 32'h0, B_SINGLE, 3'd2, 1'b1);   expect_beat("rst.new", 32'h600, 4'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_burst_tracker.md
# ahb_burst_tracker

Parametrised AHB-Lite read-burst tracker for the I-cache slave/refill path. It covers all eight HBURST types and every legal HSIZE. It follows the AHB address/data pipeline, computes the expected address of each beat (incrementing, wrapping, undefined-length INCR), and delivers one registered read beat per completed data phase with beat index and last flag. An optional checker flags protocol-violating SEQ addresses.

## Interface
- ADDR_W, 32, address width (≥12).
- DATA_W, 32, data bus width; one of 32/64/128.
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- haddr  in  ADDR_W  AHB address-phase address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1 = write (tracked, never reported).
- hburst  in  3  SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- hsize  in  3  transfer bytes = 1<<hsize.
- hready  in  1  bus ready; ends both the address and data phases.
- hrdata  in  DATA_W  read data, valid in a data phase with hready=1.
- rd_valid  out  1  one-cycle beat strobe.
- rd_addr  out  ADDR_W  address of the delivered beat.
- rd_data  out  DATA_W  data of the delivered beat.
- rd_beat  out  4  beat index within the burst, 0-based.
- rd_last  out  1  final beat of a fixed-length burst, or of a SINGLE transfer.
- burst_err  out  1  one-cycle protocol-error pulse.

## Operation
- Address phase accepted when hready=1 and htrans is NONSEQ or SEQ. IDLE and BUSY are never accepted and do not advance the beat counter.
- Accepted phase latched into the data-phase register: addr, hwrite, beat index, last flag.
- State machine:
  - IDLE → FIXED on NONSEQ with a fixed-length hburst.
  - IDLE → UNDEF on NONSEQ with INCR.
  - SINGLE stays in IDLE, with last=1 and beat 0.
  - FIXED → IDLE on acceptance of the final beat.
  - A NONSEQ in any state restarts tracking from its haddr with beat 0. This is an early termination; no error is raised.
  - An IDLE htrans in FIXED or UNDEF returns to IDLE.
- Beat count per burst type: 4, 8 or 16 for the fixed-length types; unbounded for UNDEF, where the counter saturates at 15.
- Next expected address = current + (1<<hsize).
- WRAP bursts: boundary = beats × (1<<hsize), a power of two. The expected address keeps the upper bits (addr & ~(boundary-1)), and the offset wraps modulo boundary.
- INCR bursts: plain increment, no wrap.
- Width rules:
  - Address arithmetic is ADDR_W bits.
  - Increment overflow wraps modulo 2^ADDR_W.
- Delivery: when the data-phase register holds a read and hready=1, the registered outputs load on that edge. Loaded values: rd_valid=1, rd_addr, rd_data=hrdata, rd_beat, rd_last.
- Writes complete silently.
- Wait states (hready=0): the data-phase register, address-phase tracking and counter all hold.

## Timing
- Reset: every output is 0, state is IDLE, and the data-phase register is empty.
- Reset mid-burst drops any in-flight beat; no rd_valid follows.
- Latency: rd_valid is high in the cycle after the data-phase cycle in which hready=1. One beat per cycle maximum.
- Back-to-back zero-wait beats produce consecutive rd_valid cycles.
- The final data phase coinciding with a new NONSEQ address phase is legal: the old beat is delivered and the new burst is tracked with no bubble.
- BUSY inserted mid-burst: the expected address and beat index are unchanged when SEQ resumes.

## Configuration
- AHB_TRK_CHECK_EN defined:
  - Each accepted SEQ is compared with the expected address.
  - A mismatch pulses burst_err one cycle after acceptance.
  - burst_err also pulses for a hsize above log2(DATA_W/8).
  - burst_err also pulses for an UNDEF increment crossing a 1 KB boundary.
  - On any error, tracking resyncs to the presented haddr.
- AHB_TRK_CHECK_EN undefined:
  - The comparator is not built; burst_err is tied 0.
  - rd_addr is taken from the latched haddr; beat and last counting are unchanged.

## Test plan
- SINGLE read at 0x100, zero wait → one rd_valid, rd_addr=0x100, rd_beat=0, rd_last=1.
- WRAP4 word read starting 0x38, zero wait → rd_addr 0x38, 0x3C, 0x30, 0x34 on four consecutive cycles; rd_last only on 0x34.
- INCR8 halfword burst from 0x200 with hready=0 for 2 cycles at beat 3 → addresses step by 2 to 0x20E; rd_valid gaps exactly 2 cycles; rd_beat 0–7.
- WRAP8 with BUSY after beat 2, then NONSEQ at 0x400 after beat 5 → six beats delivered; new burst starts at rd_beat=0, rd_addr=0x400; no burst_err.
- With AHB_TRK_CHECK_EN, INCR4 from 0x10 with beat 2 driven as 0x20 → burst_err pulses once; following beat expected at 0x24.
- rstn asserted during beat 2 of INCR16 → all outputs 0 immediately; no further rd_valid until a new NONSEQ.
